// File: rtl/logic_op_scheduler_pkg.sv
// Shared types for the logic-op scheduler:
// op codes and FSM states.
package logic_op_pkg;

  typedef enum logic [1:0] {
    OP_AND,
    OP_OR,
    OP_XOR,
    OP_NAND
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXEC,
    S_RESP
  } state_e;

endpackage

// File: rtl/logic_op_scheduler_if.sv
// Request/response bundle between requesters
// and the shared logic-op scheduler.
interface logic_op_scheduler_if #(
  parameter int NREQ = 4,
  parameter int W    = 8
);
  localparam int IW = $clog2(NREQ);

  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*W-1:0] req_a;
  logic [NREQ*W-1:0] req_b;
  logic [NREQ*2-1:0] req_op;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [W-1:0]      rsp_data;
  logic [IW-1:0]     rsp_id;
  logic              busy;

  modport master (
    output req_valid,
    output req_a,
    output req_b,
    output req_op,
    output rsp_ready,
    input  req_ready,
    input  rsp_valid,
    input  rsp_data,
    input  rsp_id,
    input  busy
  );

  modport slave (
    input  req_valid,
    input  req_a,
    input  req_b,
    input  req_op,
    input  rsp_ready,
    output req_ready,
    output rsp_valid,
    output rsp_data,
    output rsp_id,
    output busy
  );

endinterface

// File: rtl/logic_op_scheduler_logic_unit.sv
// Combinational W-bit bitwise unit:
// AND / OR / XOR / NAND selected by op.
import logic_op_pkg::*;

module logic_unit #(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  op_e          op,
  output logic [W-1:0] y
);

  always_comb begin
    y = '0;
    unique case (op)
      OP_AND:  y = a & b;
      OP_OR:   y = a | b;
      OP_XOR:  y = a ^ b;
      OP_NAND: y = ~(a & b);
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/logic_op_scheduler.sv
// Round-robin scheduler sharing one logic unit
// among NREQ requesters; registered response.
import logic_op_pkg::*;

module logic_op_scheduler #(
  parameter int NREQ = 4,
  parameter int W    = 8
) (
  input logic clk,
  input logic rst,
  logic_op_scheduler_if.slave bus
);

  localparam int IW = $clog2(NREQ);

  state_e state;
  state_e state_nx;

  logic [IW-1:0]   rr_ptr;
  logic [IW-1:0]   win;
  logic            found;
  logic [NREQ-1:0] grant;

  logic [W-1:0]  sel_a;
  logic [W-1:0]  sel_b;
  op_e           sel_op;

  logic [W-1:0]  op_a;
  logic [W-1:0]  op_b;
  op_e           op_op;
  logic [IW-1:0] op_id;
  logic [W-1:0]  alu_y;

  logic          rsp_valid_q;
  logic [W-1:0]  rsp_data_q;
  logic [IW-1:0] rsp_id_q;

  // first valid requester at or after rr_ptr, wrapping
  always_comb begin
    int j;
    found = 1'b0;
    win   = '0;
    j     = 0;
    for (int k = 0; k < NREQ; k++) begin
      j = int'(rr_ptr) + k;
      if (j >= NREQ) j = j - NREQ;
      if (!found && bus.req_valid[j]) begin
        found = 1'b1;
        win   = IW'(j);
      end
    end
  end

  assign grant = found ? (NREQ'(1) << win) : '0;

  always_comb begin
    sel_a  = bus.req_a[int'(win)*W +: W];
    sel_b  = bus.req_b[int'(win)*W +: W];
    sel_op = op_e'(bus.req_op[int'(win)*2 +: 2]);
  end

  logic_unit #(.W(W)) u_lu (
    .a  (op_a),
    .b  (op_b),
    .op (op_op),
    .y  (alu_y)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE:  if (found) state_nx = S_EXEC;
      S_EXEC:  state_nx = S_RESP;
      S_RESP:  if (rsp_valid_q && bus.rsp_ready)
                 state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    bus.req_ready = '0;
    if (state == S_IDLE && !rst)
      bus.req_ready = grant;
    bus.busy = (state != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr      <= '0;
      op_a        <= '0;
      op_b        <= '0;
      op_op       <= OP_AND;
      op_id       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_id_q    <= '0;
    end else begin
      unique case (state)
        S_IDLE: if (found) begin
          op_a  <= sel_a;
          op_b  <= sel_b;
          op_op <= sel_op;
          op_id <= win;
        end
        S_EXEC: begin
          rsp_data_q  <= alu_y;
          rsp_id_q    <= op_id;
          rsp_valid_q <= 1'b1;
          rr_ptr <= (op_id == IW'(NREQ-1))
                    ? '0 : op_id + IW'(1);
        end
        S_RESP: if (bus.rsp_ready)
          rsp_valid_q <= 1'b0;
        default: ;
      endcase
    end
  end

  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_id    = rsp_id_q;

endmodule

// File: tb/tb_logic_op_scheduler.sv
// Directed, table-driven bench for the
// round-robin logic-op scheduler.
module tb_logic_op_scheduler;

  localparam int NREQ = 4;
  localparam int W    = 8;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  logic_op_scheduler_if #(.NREQ(NREQ), .W(W)) bus ();

  logic_op_scheduler #(.NREQ(NREQ), .W(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int checks   = 0;
  int failures = 0;

  typedef struct {
    int         id;
    logic [7:0] a;
    logic [7:0] b;
    logic [1:0] op;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs [7];
  logic [7:0] rr_exp [4];

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h",
               nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int id,
                         input logic [7:0] a,
                         input logic [7:0] b,
                         input logic [1:0] op);
    bus.req_a[id*W +: W] = a;
    bus.req_b[id*W +: W] = b;
    bus.req_op[id*2 +: 2] = op;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  // one lone request, rsp_ready held high
  task automatic txn(input int id,
                     input logic [7:0] a,
                     input logic [7:0] b,
                     input logic [1:0] op,
                     input logic [7:0] exp);
    set_req(id, a, b, op);
    bus.req_valid = NREQ'(1) << id;
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    chk("grant", bus.req_ready, NREQ'(1) << id);
    chk("idle_busy", bus.busy, 0);
    step();
    bus.req_valid = '0;
    @(negedge clk);
    chk("exec_valid", bus.rsp_valid, 0);
    chk("exec_busy", bus.busy, 1);
    step();
    @(negedge clk);
    chk("rsp_valid", bus.rsp_valid, 1);
    chk("rsp_data", bus.rsp_data, exp);
    chk("rsp_id", bus.rsp_id, id);
    step();
    @(negedge clk);
    chk("rsp_drop", bus.rsp_valid, 0);
    chk("back_idle", bus.busy, 0);
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: timeout reached");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0] = '{1, 8'hF0, 8'h3C, 2'd0, 8'h30};
    vecs[1] = '{0, 8'hAA, 8'h0F, 2'd0, 8'h0A};
    vecs[2] = '{0, 8'hAA, 8'h0F, 2'd1, 8'hAF};
    vecs[3] = '{0, 8'hAA, 8'h0F, 2'd2, 8'hA5};
    vecs[4] = '{0, 8'hAA, 8'h0F, 2'd3, 8'hF5};
    vecs[5] = '{2, 8'hFF, 8'h0F, 2'd2, 8'hF0};
    vecs[6] = '{3, 8'hC3, 8'h5A, 2'd3, 8'hBD};

    rr_exp[0] = 8'h10;
    rr_exp[1] = 8'hF4;
    rr_exp[2] = 8'hA6;
    rr_exp[3] = 8'h8F;

    bus.req_valid = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.req_op    = '0;
    bus.rsp_ready = 1'b0;
    rst           = 1'b0;
    #1;
    do_reset();

    @(negedge clk);
    chk("rst_valid", bus.rsp_valid, 0);
    chk("rst_data", bus.rsp_data, 0);
    chk("rst_id", bus.rsp_id, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_ready", bus.req_ready, 0);
    step();

    for (int v = 0; v < 7; v++)
      txn(vecs[v].id, vecs[v].a, vecs[v].b,
          vecs[v].op, vecs[v].exp);

    // all valid: grants rotate 0,1,2,3,0,1
    do_reset();
    set_req(0, 8'h12, 8'hF0, 2'd0);
    set_req(1, 8'h34, 8'hF0, 2'd1);
    set_req(2, 8'h56, 8'hF0, 2'd2);
    set_req(3, 8'h78, 8'hF0, 2'd3);
    bus.req_valid = 4'b1111;
    bus.rsp_ready = 1'b1;
    for (int t = 0; t < 6; t++) begin
      @(negedge clk);
      chk("rr_grant", bus.req_ready,
          NREQ'(1) << (t % 4));
      step();
      @(negedge clk);
      chk("rr_exec_rdy", bus.req_ready, 0);
      step();
      @(negedge clk);
      chk("rr_id", bus.rsp_id, t % 4);
      chk("rr_data", bus.rsp_data, rr_exp[t % 4]);
      chk("rr_resp_rdy", bus.req_ready, 0);
      step();
    end

    // serve 3, then 0101 gives 0 then 2
    txn(3, 8'h0F, 8'hF0, 2'd1, 8'hFF);
    bus.req_valid = 4'b0101;
    @(negedge clk);
    chk("wrap_grant0", bus.req_ready, 4'b0001);
    step();
    step();
    @(negedge clk);
    chk("wrap_id0", bus.rsp_id, 0);
    chk("wrap_data0", bus.rsp_data, 8'h10);
    step();
    @(negedge clk);
    chk("skip_grant2", bus.req_ready, 4'b0100);
    step();
    step();
    @(negedge clk);
    chk("skip_id2", bus.rsp_id, 2);
    chk("skip_data2", bus.rsp_data, 8'hA6);
    step();
    bus.req_valid = '0;

    // backpressure on requester 2
    set_req(2, 8'h3C, 8'h0F, 2'd1);
    bus.req_valid = 4'b0100;
    bus.rsp_ready = 1'b0;
    @(negedge clk);
    chk("bp_grant", bus.req_ready, 4'b0100);
    step();
    bus.req_valid = 4'b1011;
    step();
    @(negedge clk);
    chk("bp_rise", bus.rsp_valid, 1);
    for (int k = 0; k < 5; k++) begin
      step();
      @(negedge clk);
      chk("bp_valid", bus.rsp_valid, 1);
      chk("bp_data", bus.rsp_data, 8'h3F);
      chk("bp_id", bus.rsp_id, 2);
      chk("bp_busy", bus.busy, 1);
      chk("bp_ready", bus.req_ready, 0);
    end
    bus.rsp_ready = 1'b1;
    step();
    bus.req_valid = '0;
    @(negedge clk);
    chk("bp_done", bus.rsp_valid, 0);
    chk("bp_idle", bus.busy, 0);
    step();

    // reset during EXEC
    set_req(3, 8'hF0, 8'h0F, 2'd1);
    bus.req_valid = 4'b1000;
    @(negedge clk);
    chk("rx_grant", bus.req_ready, 4'b1000);
    step();
    bus.req_valid = '0;
    rst = 1'b1;
    @(negedge clk);
    chk("rx_busy", bus.busy, 1);
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("rx_valid", bus.rsp_valid, 0);
    chk("rx_data", bus.rsp_data, 0);
    chk("rx_id", bus.rsp_id, 0);
    chk("rx_busy0", bus.busy, 0);
    step();

    // reset during RESP, after rr_ptr moved to 2
    set_req(1, 8'hFF, 8'h0F, 2'd1);
    bus.req_valid = 4'b0010;
    bus.rsp_ready = 1'b0;
    @(negedge clk);
    chk("rr2_grant", bus.req_ready, 4'b0010);
    step();
    bus.req_valid = '0;
    step();
    @(negedge clk);
    chk("rr2_valid", bus.rsp_valid, 1);
    chk("rr2_data", bus.rsp_data, 8'hFF);
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("rr2_valid0", bus.rsp_valid, 0);
    chk("rr2_data0", bus.rsp_data, 0);
    chk("rr2_id0", bus.rsp_id, 0);
    chk("rr2_busy0", bus.busy, 0);
    step();

    // rr_ptr back at 0: lowest valid wins
    set_req(3, 8'h00, 8'h00, 2'd3);
    bus.req_valid = 4'b1010;
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    chk("post_grant", bus.req_ready, 4'b0010);
    step();
    bus.req_valid = '0;
    step();
    @(negedge clk);
    chk("post_id", bus.rsp_id, 1);
    chk("post_data", bus.rsp_data, 8'hFF);
    step();
    @(negedge clk);
    chk("post_done", bus.rsp_valid, 0);
    step();

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule

// File: doc/logic_op_scheduler.md
Name: logic_op_scheduler

Overview:
- Shares one bitwise logic unit (AND/OR/XOR/NAND) among NREQ requesters.
- Round-robin arbitration. Valid/ready request and response handshakes, registered result.
- Sits in front of the combinational and/or gate blocks and sequences their use: latch operands, execute, hold the response until accepted.

Parameters:
- NREQ, 4, number of requesters (2..8)
- W, 8, operand/result width in bits

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- req_valid  input  NREQ  per-requester request valid
- req_ready  output  NREQ  one-hot accept; bit i high for one cycle when requester i is captured
- req_a  input  NREQ*W  operand A, requester i at bits [i*W +: W]
- req_b  input  NREQ*W  operand B, same packing
- req_op  input  NREQ*2  op code per requester: 0 AND, 1 OR, 2 XOR, 3 NAND
- rsp_valid  output  1  result valid
- rsp_ready  input  1  consumer accepts result
- rsp_data  output  W  result
- rsp_id  output  $clog2(NREQ)  index of the requester served
- busy  output  1  high whenever state is not IDLE

Behaviour:
- Reset, checked synchronously at the clock edge, dominates all other inputs. Effects:
  - state=IDLE, rr_ptr=0, req_ready=0, rsp_valid=0, rsp_data=0, rsp_id=0, busy=0.
  - Applies mid-transaction: a pending result is discarded with no response.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - If any req_valid is set, pick the first set bit searching from rr_ptr upward with wrap (rr_ptr, rr_ptr+1, …, NREQ-1, 0, …).
  - req_ready[winner]=1 combinationally in that cycle. That is the capture handshake; the requester may drop valid next cycle.
  - At the edge: latch a, b, op and id into operand registers; go to EXEC.
  - No valid bits set: stay in IDLE, req_ready=0.
- EXEC, one cycle:
  - rsp_data <= logic_unit(a, b, op); rsp_id <= id; rsp_valid <= 1; go to RESP.
  - rr_ptr <= (id+1) mod NREQ, wrapping from NREQ-1 to 0.
- RESP:
  - rsp_valid held high; rsp_data and rsp_id stable until rsp_ready=1.
  - On rsp_valid && rsp_ready at the edge: rsp_valid <= 0, go to IDLE.
  - req_ready=0 throughout.
- Latency and throughput:
  - Capture edge to rsp_valid high: 2 clocks.
  - Best-case throughput is one transaction per 3 cycles. No new capture occurs in the RESP cycle, even when rsp_ready=1.
- Fairness:
  - With all requesters continuously valid, grants cycle 0,1,…,NREQ-1,0.
  - A requester waits at most NREQ-1 other transactions.
- Requester deasserting valid before being granted: legal, no effect.
- req_op outside 0..3 cannot occur (2 bits); every code is defined.
- rsp_data bits are independent per bit; no carry, no width growth.
- busy = (state != IDLE).

Decomposition:
- Package logic_op_pkg:
  - typedef enum logic [1:0] op_e {OP_AND, OP_OR, OP_XOR, OP_NAND}
  - typedef enum logic [1:0] state_e {S_IDLE, S_EXEC, S_RESP}
- Sub-module logic_unit: combinational, W-bit, inputs a, b, op, output y; case on op_e.
- Arbiter priority search stays inline in logic_op_scheduler.

Test Plan:
- Single request: rst high 2 cycles then low. req_valid=4'b0010, a=8'hF0, b=8'h3C, op=AND, rsp_ready=1. Expect:
  - req_ready=4'b0010 in the first cycle.
  - rsp_valid 2 clocks later with rsp_data=8'h30, rsp_id=1, and rsp_valid low the following cycle.
- All ops: a=8'hAA, b=8'h0F on requester 0 through ops 0..3. Expect rsp_data = 8'h0A, 8'hAF, 8'hA5, 8'hF5.
- Round-robin: req_valid=4'b1111 held, rsp_ready=1. Expect:
  - rsp_id sequence 0,1,2,3,0,1.
  - req_ready pulses exactly 3 cycles apart.
- Wrap and skip: after serving id 3, req_valid=4'b0101. Expect grant id 0 next, then id 2.
- Backpressure: rsp_ready=0 for 5 cycles after rsp_valid rises. Expect:
  - rsp_data and rsp_id constant, busy=1, req_ready=0 throughout.
  - Transaction completes on the cycle rsp_ready=1.
- Reset mid-operation: assert rst in the EXEC cycle and again in RESP. Expect the next cycle to show state IDLE, rsp_valid=0, rsp_data=0, busy=0, and the first post-reset grant to go to the lowest valid index (rr_ptr=0).
